// File: rtl/load_store_unit_if.sv
// Core-request / response / data-memory bundle for load_store_unit.
// Signal suffixes are from the LSU's point of view; the LSU binds to the
// slave modport, the core/memory side binds to master.
interface load_store_unit_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_error_o;
  logic        mem_write_o;
  logic [1:0]  mem_req_size_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_write_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
           mem_write_o, mem_req_size_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_write_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
           mem_write_o, mem_req_size_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one core request at a time, performs an
// aligned memory access or (optionally) splits a misaligned one into byte
// accesses, and returns a one-cycle response pulse.
// Ports:
//   clk_i    - clock, all state updates on the rising edge
//   reset_i  - synchronous active-low reset
//   bus      - load_store_unit_if.slave: req_* (core request), rsp_* (response),
//              mem_* (data memory, combinational read, write on clock edge)
// Parameter ALLOW_MISALIGNED: 1 = split misaligned into bytes, 0 = error.
module load_store_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  load_store_unit_if.slave bus
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NBYTES = XLEN / 8;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_BYTE, S_RESP} state_e;

  state_e            state_q;
  logic              ready_q;
  logic              write_q;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   buf_q;
  logic [2:0]        size_q;
  logic [1:0]        cnt_q;
  logic              rsp_valid_q;
  logic [XLEN-1:0]   rsp_rdata_q;
  logic              rsp_error_q;
  logic              mem_write_q;
  logic [1:0]        mem_size_q;
  logic [XLEN-1:0]   mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;

  logic [2:0]        req_size;
  logic              req_legal;
  logic              req_misal;
  logic              byte_last;
  logic [1:0]        cnt_nxt;
  logic [XLEN-1:0]   byte_merged;
  logic [7:0]        wbyte_nxt;

  // Access size in bytes from funct3[1:0]; 11 is illegal and caught by req_legal.
  always_comb begin
    case (bus.req_funct3_i[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
  end

  always_comb begin
    if (bus.req_write_i) req_legal = (bus.req_funct3_i <= 3'd2);
    else                 req_legal = (bus.req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  end

  assign req_misal = ((req_size == 3'd2) && bus.req_addr_i[0]) ||
                     ((req_size == 3'd4) && (bus.req_addr_i[1:0] != 2'b00));
  assign byte_last = ({1'b0, cnt_q} == (size_q - 3'd1));
  assign cnt_nxt   = cnt_q + 2'd1;
  assign wbyte_nxt = wdata_q[{cnt_nxt, 3'b000} +: 8];

  // Partial load result with the byte returned this cycle merged in.
  always_comb begin
    byte_merged = buf_q;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (2'(i) == cnt_q) byte_merged[8*i +: 8] = bus.mem_rdata_i[7:0];
    end
  end

  function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {24'h0, d[7:0]};
      3'b101:  return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Control FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      write_q     <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      size_q      <= 3'd0;
      cnt_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_size_q  <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (bus.req_valid_i && ready_q) begin
            ready_q  <= 1'b0;
            write_q  <= bus.req_write_i;
            funct3_q <= bus.req_funct3_i;
            addr_q   <= bus.req_addr_i;
            wdata_q  <= bus.req_wdata_i;
            size_q   <= req_size;
            cnt_q    <= 2'd0;
            buf_q    <= '0;
            if (!req_legal || (req_misal && !ALLOW_MISALIGNED)) begin
              // Error: straight to response, memory port untouched.
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (!req_misal) begin
              state_q     <= S_ACCESS;
              mem_addr_q  <= bus.req_addr_i;
              mem_size_q  <= bus.req_funct3_i[1:0];
              mem_wdata_q <= bus.req_wdata_i;
              mem_write_q <= bus.req_write_i;
            end else begin
              state_q     <= S_BYTE;
              mem_addr_q  <= bus.req_addr_i;
              mem_size_q  <= 2'b00;
              mem_wdata_q <= {24'h0, bus.req_wdata_i[7:0]};
              mem_write_q <= bus.req_write_i;
            end
          end
        end
        S_ACCESS: begin
          state_q     <= S_RESP;
          mem_write_q <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_error_q <= 1'b0;
          rsp_rdata_q <= write_q ? '0 : extend(funct3_q, bus.mem_rdata_i);
        end
        S_BYTE: begin
          if (byte_last) begin
            state_q     <= S_RESP;
            mem_write_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= write_q ? '0 : extend(funct3_q, byte_merged);
          end else begin
            cnt_q       <= cnt_nxt;
            buf_q       <= byte_merged;
            mem_addr_q  <= addr_q + XLEN'(cnt_nxt);
            mem_wdata_q <= {24'h0, wbyte_nxt};
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o    = ready_q;
  assign bus.rsp_valid_o    = rsp_valid_q;
  assign bus.rsp_rdata_o    = rsp_rdata_q;
  assign bus.rsp_error_o    = rsp_error_q;
  assign bus.mem_write_o    = mem_write_q;
  assign bus.mem_req_size_o = mem_size_q;
  assign bus.mem_addr_o     = mem_addr_q;
  assign bus.mem_wdata_o    = mem_wdata_q;

endmodule
